// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider -- radix-2 restoring integer divider, signed or unsigned operands.
//
// One quotient bit is produced per CALC cycle on operand magnitudes; the
// signs are re-applied in FIX.
//
// Latency
//   If en=1 in an IDLE cycle T, then T is the load cycle.
//   - CALC runs for cycles T+1 .. T+DATA_BITS.
//   - FIX is cycle T+DATA_BITS+1.
//   - done is high in cycle T+DATA_BITS+2.
//   - The FSM is back in IDLE in cycle T+DATA_BITS+3.
//
// Optional feature (macro DIVIDER_DIV0_CHECK_EN)
//   When the macro is defined, a zero divisor at load goes straight to DONE
//   (done at T+1) with quotient = all ones, remainder = dividend, div0 = 1.
//   When the macro is undefined, a zero divisor runs the normal sequence and
//   div0 is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   en         in   start request, sampled only in IDLE
//   sign       in   1 = signed two's-complement operands, 0 = unsigned
//   dividend   in   [DATA_BITS-1:0] dividend, sampled at load
//   divisor    in   [DATA_BITS-1:0] divisor, sampled at load
//   done       out  one-cycle completion pulse (state == DONE)
//   quotient   out  [DATA_BITS-1:0] registered quotient
//   remainder  out  [DATA_BITS-1:0] registered remainder
//   div0       out  divide-by-zero flag, meaningful while done is high
//   dbg_state  out  [1:0] FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
//
// Handshake
//   en is a request that is consumed only when the FSM is in IDLE; en seen
//   in any other state is ignored, and there is no back-pressure. done is a
//   single-cycle strobe. quotient and remainder are valid while done is high
//   and hold their values until the next FIX writes them.
// -----------------------------------------------------------------------------
module divider #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sign,
  input  logic [DATA_BITS-1:0] dividend,
  input  logic [DATA_BITS-1:0] divisor,
  output logic                 done,
  output logic [DATA_BITS-1:0] quotient,
  output logic [DATA_BITS-1:0] remainder,
  output logic                 div0,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] quo_sr;   // dividend magnitude shifting out, quotient bits shifting in
  logic [DATA_BITS-1:0] rem_r;    // partial remainder, always < dvs_r
  logic [DATA_BITS-1:0] dvs_r;    // divisor magnitude
  logic                 q_neg;    // quotient must be negated in FIX
  logic                 r_neg;    // remainder takes the dividend's sign
  logic [CW-1:0]        cnt;

  // Magnitudes at load. Negating -2^(DATA_BITS-1) yields the same bit
  // pattern, which read as unsigned is the correct magnitude, so the
  // unsigned datapath needs no extra bit.
  logic                 a_neg;
  logic                 b_neg;
  logic [DATA_BITS-1:0] mag_a;
  logic [DATA_BITS-1:0] mag_b;

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract. A borrow (diff MSB set) means the subtraction failed,
  // so the shifted value is kept and the quotient bit is 0.
  logic [DATA_BITS:0]   shifted;
  logic [DATA_BITS:0]   diff;

  always_comb begin
    a_neg   = sign & dividend[DATA_BITS-1];
    b_neg   = sign & divisor[DATA_BITS-1];
    mag_a   = a_neg ? -dividend : dividend;
    mag_b   = b_neg ? -divisor  : divisor;
    shifted = {rem_r, quo_sr[DATA_BITS-1]};
    diff    = shifted - {1'b0, dvs_r};
  end

`ifdef DIVIDER_DIV0_CHECK_EN
  logic div0_r;
  assign div0 = div0_r;
`else
  assign div0 = 1'b0;
`endif

  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      quo_sr    <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DIV0_CHECK_EN
      div0_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
`ifdef DIVIDER_DIV0_CHECK_EN
            if (divisor == '0) begin
              // Short-cut: the result is known without iterating.
              quotient  <= '1;
              remainder <= dividend;
              div0_r    <= 1'b1;
              state     <= DONE;
            end else
`endif
            begin
              quo_sr <= mag_a;
              rem_r  <= '0;
              dvs_r  <= mag_b;
              q_neg  <= a_neg ^ b_neg;
              r_neg  <= a_neg;
              cnt    <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_r  <= diff[DATA_BITS] ? shifted[DATA_BITS-1:0] : diff[DATA_BITS-1:0];
          quo_sr <= {quo_sr[DATA_BITS-2:0], ~diff[DATA_BITS]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // MIN / -1 gives magnitude 2^(DATA_BITS-1) with q_neg = 0, which
          // wraps to MIN as required.
          quotient  <= q_neg ? -quo_sr : quo_sr;
          remainder <= r_neg ? -rem_r  : rem_r;
`ifdef DIVIDER_DIV0_CHECK_EN
          div0_r    <= 1'b0;
`endif
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider -- self-checking bench for divider (DATA_BITS = 32).
//
// Directed vectors come from a constant table. Random operations are checked
// against an arithmetic reference model. Hand-written sequences cover reset
// in the middle of an operation, the first edge after reset, and
// back-to-back operation with en held high.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int W = 32;
`ifdef DIVIDER_DIV0_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div0;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard queue of expected {quotient, remainder}.
  logic [2*W-1:0] exp_q[$];

  divider #(.DATA_BITS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain integer arithmetic: SV division truncates toward zero and the
  // remainder takes the dividend's sign, matching the signed rules.
  function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == '0) begin
      q = (s && a[W-1]) ? 64'sd1 : -64'sd1;
      r = longint'({32'h0, a});
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
    end
    return {q[W-1:0], r[W-1:0]};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one operation for a single load edge, then scrambles the
  // operand inputs (they must be ignored) and waits a bounded time for done.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic d0, output int lat);
    @(negedge clk);
    en = 1'b1; sign = s; dividend = a; divisor = b;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        en = 1'b0;
        sign = 1'($urandom);
        dividend = $urandom;
        divisor = $urandom;
      end
    end while (!done && lat < 200);
    q = quotient; r = remainder; d0 = div0;
  endtask

  task automatic run_check(input string name, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d0;
    int           lat;
    logic         zero_short;
    zero_short = CHK && (b == '0);
    do_op(s, a, b, q, r, d0, lat);
    check({name, " latency"}, 64'(lat), zero_short ? 64'd1 : 64'(W + 2));
    check({name, " quotient"}, 64'(q), 64'(eq));
    check({name, " remainder"}, 64'(r), 64'(er));
    check({name, " div0"}, 64'(d0), 64'(zero_short));
    @(posedge clk); #1;
    check({name, " done width"}, 64'(done), 64'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string        name;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic         seen;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] e;
    int           mode;

    vecs[0] = '{"u 100/7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"s -7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{"s 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{"s MIN/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{"u max/1",      1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[5] = '{"u 5/9",        1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
    vecs[6] = '{"u 123/0",      1'b0, 32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123};
    vecs[7] = '{"s -123/0",     1'b1, 32'hFFFF_FF85,  32'd0,          CHK ? 32'hFFFF_FFFF : 32'd1, 32'hFFFF_FF85};
    vecs[8] = '{"u MIN/max",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[9] = '{"s -100/-7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};

    // ---- reset ----
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset div0", 64'(div0), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    // Release between edges so the first edge afterwards can load.
    rst = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 10; i++) begin
      run_check(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    end

    // ---- reset in the middle of CALC ----
    @(negedge clk);
    en = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;            // load edge done, now cycle T+1
    en = 1'b0;
    repeat (9) @(posedge clk);     // cycle T+10
    #2 rst = 1'b0;
    #1;
    check("midreset done", 64'(done), 64'd0);
    check("midreset quotient", 64'(quotient), 64'd0);
    check("midreset remainder", 64'(remainder), 64'd0);
    check("midreset div0", 64'(div0), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abandoned op no done", 64'(seen), 64'd0);

    // ---- en accepted on first edge after reset release ----
    rst = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    e = ref_div(1'b0, 32'd77777, 32'd123);
    run_check("after release", 1'b0, 32'd77777, 32'd123, e[2*W-1:W], e[W-1:0]);

    // ---- randomized operations vs reference model ----
    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 5));
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = '0;
      else if (mode == 1) begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 20));
      else if (mode == 3) b = -32'($urandom_range(1, 20));
      e = ref_div(s, a, b);
      run_check($sformatf("rand%0d", i), s, a, b, e[2*W-1:W], e[W-1:0]);
    end

    // ---- back-to-back with en held high ----
    // Loads happen every W+3 edges starting with the first one; done is
    // expected W+1 edges after each load edge.
    for (int k = 0; k < 4 * (W + 3); k++) begin
      @(negedge clk);
      en = 1'b1;
      sign = 1'($urandom);
      dividend = $urandom;
      do divisor = $urandom; while (divisor == '0);
      if (k % (W + 3) == 0) exp_q.push_back(ref_div(sign, dividend, divisor));
      @(posedge clk); #1;
      if (done !== (k % (W + 3) == W + 1)) begin
        check($sformatf("b2b done at edge %0d", k), 64'(done), 64'(k % (W + 3) == W + 1));
      end
      if (k % (W + 3) == W + 1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b scoreboard empty at edge %0d: got=%h expected=none", k,
                   {quotient, remainder});
        end else begin
          check($sformatf("b2b result edge %0d", k), {quotient, remainder}, exp_q.pop_front());
        end
      end
    end
    en = 1'b0;
    check("b2b queue drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, operand width in bits (minimum 4).
REQ-002 SHALL have port clk, input, 1 bit, main clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1 bit, start request, sampled only in IDLE.
REQ-005 SHALL have port sign, input, 1 bit, signed (1) or unsigned (0) operands, sampled with en.
REQ-006 SHALL have port dividend, input, DATA_BITS, dividend operand.
REQ-007 SHALL have port divisor, input, DATA_BITS, divisor operand.
REQ-008 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-009 SHALL have port quotient, output, DATA_BITS, registered quotient.
REQ-010 SHALL have port remainder, output, DATA_BITS, registered remainder.
REQ-011 SHALL have port div0, output, 1 bit, divide-by-zero flag, valid while done is high.

Function
REQ-012 SHALL implement a radix-2 restoring divider, one quotient bit per CALC cycle.
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE; reset state is IDLE.
REQ-014 SHALL leave IDLE only on en=1: load cycle T latches sign, operand magnitudes and result signs, clears the bit counter, then goes to CALC.
REQ-015 SHALL stay in CALC exactly DATA_BITS cycles (T+1 .. T+DATA_BITS), then go to FIX.
REQ-016 SHALL apply the sign correction and write quotient/remainder in FIX (T+DATA_BITS+1), then go to DONE.
REQ-017 SHALL assert done high for exactly the DONE cycle (T+DATA_BITS+2), decoded from state, then return to IDLE.
REQ-018 SHALL ignore en outside IDLE; en held high in DONE starts the next operation only from the following IDLE cycle.
REQ-019 SHALL ignore dividend, divisor and sign changes after the load cycle.
REQ-020 SHALL hold quotient, remainder and div0 stable from DONE until the next FIX (or next DONE for div0).
REQ-021 Unsigned mode SHALL give floor quotient, with remainder < divisor.
REQ-022 Signed mode SHALL be two's complement, quotient truncated toward zero, remainder sign equal to dividend sign, |remainder| < |divisor|.
REQ-023 SHALL handle magnitude of -2^(DATA_BITS-1) without overflow in the internal magnitude path.
REQ-024 SHALL return, for signed MIN / -1, quotient = MIN (wrap) and remainder = 0, with div0 = 0.

Reset
REQ-025 SHALL on rst=0, asynchronously and regardless of state, force IDLE, done=0, quotient=0, remainder=0, div0=0, and clear all internal registers.
REQ-026 SHALL abandon an operation interrupted by reset; no done pulse for it.
REQ-027 SHALL accept en on the first rising clk edge after rst deasserts.

Configuration
REQ-028 SHALL support macro DIVIDER_DIV0_CHECK_EN.
REQ-029 With DIVIDER_DIV0_CHECK_EN defined, divisor=0 at load SHALL skip CALC/FIX: DONE at T+1, quotient = all ones, remainder = dividend, div0 = 1.
REQ-030 Without DIVIDER_DIV0_CHECK_EN, divisor=0 SHALL run normal latency with natural results: unsigned quotient all ones, remainder = dividend; signed quotient all ones if dividend >= 0, else 1, remainder = dividend. div0 SHALL be tied 0.

Verification (DATA_BITS=32)
REQ-031 Unsigned: en at T, sign=0, 100/7 -> done only at T+34, quotient=14, remainder=2, div0=0.
REQ-032 Signed: -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); 7/-2 -> quotient=-3, remainder=1; 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-033 Unsigned extremes: 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; 5/9 -> quotient=0, remainder=5; operands toggled mid-CALC do not change the result.
REQ-034 Reset mid-operation: rst low at T+10 -> done, quotient, remainder, div0 all 0 at once; no done at T+34; new en after release gives done 34 cycles later.
REQ-035 Divide by zero: 123/0 unsigned -> with DIVIDER_DIV0_CHECK_EN, done at T+1, quotient=0xFFFFFFFF, remainder=123, div0=1; without it, done at T+34, same quotient/remainder, div0=0.
REQ-036 Back-to-back: en held high continuously -> done pulses every 35 cycles, each a single cycle, results correct for the operands presented at each load cycle.
